// File: rtl/datapath.sv
// K&S datapath: PC, IR, 4-entry register file, ALU and registered ALU flags; sole RAM port master.
// Latency: ram_addr/data_out/decoded_instruction are combinational; state and flags update one edge later.
// Backpressure: none; every enable is honoured on the edge it is asserted.
//
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   branch, pc_enable    PC update control (branch target = IR[4:0], else PC+1)
//   ir_enable            capture data_in into IR
//   write_reg_enable     write register file; c_sel picks ALU result (1) or data_in (0)
//   addr_sel             RAM address source: 0 = PC, 1 = IR[4:0]
//   operation            ALU op: 00 OR, 01 ADD, 10 SUB, 11 AND
//   flags_reg_enable     capture ALU flags
//   decoded_instruction  IR opcode decode
//   zero_op, neg_op, unsigned_overflow, signed_overflow  registered ALU flags
//   ram_addr, data_out, data_in  RAM port

package k_and_s_pkg;
    typedef enum logic [3:0] {
        I_NOP, I_LOAD, I_STORE, I_MOVE,
        I_ADD, I_SUB, I_AND, I_OR,
        I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG,
        I_HALT
    } decoded_instruction_type;
endpackage

module datapath #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    branch,
    input  logic                                    pc_enable,
    input  logic                                    ir_enable,
    input  logic                                    write_reg_enable,
    input  logic                                    addr_sel,
    input  logic                                    c_sel,
    input  logic [1:0]                              operation,
    input  logic                                    flags_reg_enable,
    output k_and_s_pkg::decoded_instruction_type    decoded_instruction,
    output logic                                    zero_op,
    output logic                                    neg_op,
    output logic                                    unsigned_overflow,
    output logic                                    signed_overflow,
    output logic [ADDR_W-1:0]                       ram_addr,
    output logic [DATA_W-1:0]                       data_out,
    input  logic [DATA_W-1:0]                       data_in
);
    import k_and_s_pkg::*;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] regs_q [4];
    logic              zero_q, neg_q, uo_q, so_q;

    decoded_instruction_type dec;

    logic [1:0]        dst_sel, a_sel, b_sel;
    logic [DATA_W-1:0] alu_a, alu_b, alu_res, wr_dat;
    logic [DATA_W:0]   sum_w, diff_w;
    logic              alu_uo, alu_so;

    // IR bit 7 is not used by any encoding.
    logic unused_ir7;
    assign unused_ir7 = ir_q[7];

    // ---------------- decode ----------------
    always_comb begin
        dec = I_NOP;
        case (ir_q[15:8])
            8'h81:   dec = I_LOAD;
            8'h82:   dec = I_STORE;
            8'h91:   dec = I_MOVE;
            8'hA1:   dec = I_ADD;
            8'hA2:   dec = I_SUB;
            8'hA3:   dec = I_AND;
            8'hA4:   dec = I_OR;
            8'h01:   dec = I_BRANCH;
            8'h02:   dec = I_BZERO;
            8'h03:   dec = I_BNZERO;
            8'h04:   dec = I_BNEG;
            8'h05:   dec = I_BNNEG;
            8'hFF:   dec = I_HALT;
            default: dec = I_NOP;
        endcase
    end
    assign decoded_instruction = dec;

    // Destination field moves with the instruction format; MOVE feeds its
    // source to both ALU ports so an OR passes the value straight through.
    always_comb begin
        dst_sel = ir_q[5:4];
        a_sel   = ir_q[3:2];
        if (dec == I_LOAD) dst_sel = ir_q[6:5];
        if (dec == I_MOVE) begin
            dst_sel = ir_q[3:2];
            a_sel   = ir_q[1:0];
        end
    end
    assign b_sel = ir_q[1:0];

    assign alu_a = regs_q[a_sel];
    assign alu_b = regs_q[b_sel];

    // ---------------- ALU ----------------
    // The extra MSB of the (DATA_W+1)-bit difference is the unsigned borrow (A<B).
    assign sum_w  = {1'b0, alu_a} + {1'b0, alu_b};
    assign diff_w = {1'b0, alu_a} - {1'b0, alu_b};

    always_comb begin
        alu_res = '0;
        alu_uo  = 1'b0;
        alu_so  = 1'b0;
        case (operation)
            2'b00: alu_res = alu_a | alu_b;
            2'b01: begin
                alu_res = sum_w[DATA_W-1:0];
                alu_uo  = sum_w[DATA_W];
                alu_so  = (alu_a[DATA_W-1] == alu_b[DATA_W-1]) &&
                          (sum_w[DATA_W-1] != alu_a[DATA_W-1]);
            end
            2'b10: begin
                alu_res = diff_w[DATA_W-1:0];
                alu_uo  = diff_w[DATA_W];
                alu_so  = (alu_a[DATA_W-1] != alu_b[DATA_W-1]) &&
                          (diff_w[DATA_W-1] != alu_a[DATA_W-1]);
            end
            default: alu_res = alu_a & alu_b;
        endcase
    end

    assign wr_dat = c_sel ? alu_res : data_in;

    // ---------------- PC ----------------
    always_comb begin
        pc_d = pc_q;
        if (pc_enable) pc_d = branch ? ir_q[ADDR_W-1:0] : pc_q + 1'b1;
    end

    // ---------------- state ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= '0;
            ir_q   <= '0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            uo_q   <= 1'b0;
            so_q   <= 1'b0;
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
        end else begin
            pc_q <= pc_d;
            if (ir_enable) ir_q <= data_in;
            // Uses the pre-edge IR fields even when IR is reloaded on this edge.
            if (write_reg_enable) regs_q[dst_sel] <= wr_dat;
            if (flags_reg_enable) begin
                zero_q <= (alu_res == '0);
                neg_q  <= alu_res[DATA_W-1];
                uo_q   <= alu_uo;
                so_q   <= alu_so;
            end
        end
    end

    assign zero_op           = zero_q;
    assign neg_op            = neg_q;
    assign unsigned_overflow = uo_q;
    assign signed_overflow   = so_q;

    assign ram_addr = addr_sel ? ir_q[ADDR_W-1:0] : pc_q;
    assign data_out = regs_q[ir_q[6:5]];

endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath: expected values queued at stimulus time, popped at observation.
// Inputs change 1 time unit after the rising edge; outputs are observed there too.
// Registers are observed through data_out (IR[6:5]) and PC through ram_addr with addr_sel=0.
module tb_datapath;
    import k_and_s_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel, flags_reg_enable;
    logic [1:0]  operation;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic [4:0]  ram_addr;
    logic        zero_op, neg_op, unsigned_overflow, signed_overflow;
    decoded_instruction_type decoded_instruction;

    datapath #(.DATA_W(16), .ADDR_W(5)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .branch              (branch),
        .pc_enable           (pc_enable),
        .ir_enable           (ir_enable),
        .write_reg_enable    (write_reg_enable),
        .addr_sel            (addr_sel),
        .c_sel               (c_sel),
        .operation           (operation),
        .flags_reg_enable    (flags_reg_enable),
        .decoded_instruction (decoded_instruction),
        .zero_op             (zero_op),
        .neg_op              (neg_op),
        .unsigned_overflow   (unsigned_overflow),
        .signed_overflow     (signed_overflow),
        .ram_addr            (ram_addr),
        .data_out            (data_out),
        .data_in             (data_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic expect_val(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic observe(input logic [31:0] obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL sb_empty: observed %h with no expectation queued", obs);
        end else begin
            e = sb_q.pop_front();
            n_cmp++;
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    function automatic logic [31:0] flags();
        return {28'd0, zero_op, neg_op, unsigned_overflow, signed_overflow};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ir(input logic [15:0] v);
        data_in   = v;
        ir_enable = 1'b1;
        step();
        ir_enable = 1'b0;
    endtask

    // Write R[n] via a LOAD instruction with data_in as write data.
    task automatic write_reg(input logic [1:0] n, input logic [15:0] v);
        load_ir(16'h8100 | (16'(n) << 5));
        data_in          = v;
        c_sel            = 1'b0;
        write_reg_enable = 1'b1;
        step();
        write_reg_enable = 1'b0;
    endtask

    task automatic alu_op(input logic [15:0] ir, input logic [1:0] op);
        load_ir(ir);
        operation        = op;
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
        flags_reg_enable = 1'b1;
        step();
        write_reg_enable = 1'b0;
        flags_reg_enable = 1'b0;
        c_sel            = 1'b0;
    endtask

    logic [15:0]             dec_ir  [7];
    decoded_instruction_type dec_exp [7];

    initial begin
        rst_n = 1'b0; branch = 0; pc_enable = 0; ir_enable = 0; write_reg_enable = 0;
        addr_sel = 0; c_sel = 0; operation = 2'b00; flags_reg_enable = 0; data_in = '0;

        // Reset state
        #1;
        expect_val("rst_ram_addr", 32'd0);        observe(32'(ram_addr));
        expect_val("rst_data_out", 32'd0);        observe(32'(data_out));
        expect_val("rst_decode",   32'(I_NOP));   observe(32'(decoded_instruction));
        expect_val("rst_flags",    32'd0);        observe(flags());
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // LOAD fetch, then RAM address from IR and register write from data_in
        load_ir(16'h8125);
        expect_val("load_decode", 32'(I_LOAD));   observe(32'(decoded_instruction));
        addr_sel = 1'b1;
        #1;
        expect_val("load_addr", 32'd5);           observe(32'(ram_addr));
        data_in = 16'h1234; c_sel = 1'b0; write_reg_enable = 1'b1;
        step();
        write_reg_enable = 1'b0; addr_sel = 1'b0;
        expect_val("load_r1", 32'h1234);          observe(32'(data_out));

        // ADD signed overflow: R0 = R3 + R2 = 1 + 7FFF
        write_reg(2'd2, 16'h7FFF);
        write_reg(2'd3, 16'h0001);
        alu_op(16'hA10E, 2'b01);
        expect_val("add_res",   32'h8000);        observe(32'(data_out));
        expect_val("add_flags", 32'b0101);        observe(flags());

        // SUB equal operands: zero
        write_reg(2'd1, 16'd3);
        write_reg(2'd2, 16'd3);
        alu_op(16'hA206, 2'b10);
        expect_val("sub_zero_res",   32'h0000);   observe(32'(data_out));
        expect_val("sub_zero_flags", 32'b1000);   observe(flags());

        // SUB borrow: 2 - 3
        write_reg(2'd1, 16'd2);
        alu_op(16'hA206, 2'b10);
        expect_val("sub_brw_res",   32'hFFFF);    observe(32'(data_out));
        expect_val("sub_brw_flags", 32'b0110);    observe(flags());
        load_ir(16'h8220);
        expect_val("flags_hold", 32'b0110);       observe(flags());

        // PC increment up to 31, wrap to 0
        addr_sel = 1'b0;
        expect_val("pc_start", 32'd0);            observe(32'(ram_addr));
        pc_enable = 1'b1;
        for (int i = 0; i < 31; i++) step();
        expect_val("pc_31", 32'd31);              observe(32'(ram_addr));
        step();
        pc_enable = 1'b0;
        expect_val("pc_wrap", 32'd0);             observe(32'(ram_addr));

        // Branch without pc_enable: no effect; with pc_enable: jump
        load_ir(16'h0113);
        expect_val("br_decode", 32'(I_BRANCH));   observe(32'(decoded_instruction));
        branch = 1'b1;
        step();
        expect_val("br_no_en", 32'd0);            observe(32'(ram_addr));
        pc_enable = 1'b1;
        step();
        pc_enable = 1'b0; branch = 1'b0;
        expect_val("br_target", 32'd19);          observe(32'(ram_addr));

        // pc_enable with ir_enable on the same edge
        data_in = 16'h0205; ir_enable = 1'b1; pc_enable = 1'b1;
        step();
        ir_enable = 1'b0; pc_enable = 1'b0;
        expect_val("pcir_pc",  32'd20);           observe(32'(ram_addr));
        expect_val("pcir_dec", 32'(I_BZERO));     observe(32'(decoded_instruction));

        // MOVE R1 <- R3 through ALU OR
        write_reg(2'd3, 16'hBEEF);
        alu_op(16'h9107, 2'b00);
        load_ir(16'h8220);
        expect_val("store_decode", 32'(I_STORE)); observe(32'(decoded_instruction));
        expect_val("move_r1", 32'hBEEF);          observe(32'(data_out));

        // ir_enable with write_reg_enable: write uses the old IR (LOAD R2)
        load_ir(16'h8140);
        data_in = 16'h8160; ir_enable = 1'b1; write_reg_enable = 1'b1; c_sel = 1'b0;
        step();
        ir_enable = 1'b0; write_reg_enable = 1'b0;
        expect_val("irwr_r3", 32'hBEEF);          observe(32'(data_out));
        load_ir(16'h8240);
        expect_val("irwr_r2", 32'h8160);          observe(32'(data_out));

        // AND: R0 = R3 & R2 = BEEF & 8160
        alu_op(16'hA30E, 2'b11);
        expect_val("and_res",   32'h8060);        observe(32'(data_out));
        expect_val("and_flags", 32'b0100);        observe(flags());

        // Remaining decodes
        dec_ir[0] = 16'hA300; dec_exp[0] = I_AND;
        dec_ir[1] = 16'hA400; dec_exp[1] = I_OR;
        dec_ir[2] = 16'hFF00; dec_exp[2] = I_HALT;
        dec_ir[3] = 16'h0300; dec_exp[3] = I_BNZERO;
        dec_ir[4] = 16'h0400; dec_exp[4] = I_BNEG;
        dec_ir[5] = 16'h0500; dec_exp[5] = I_BNNEG;
        dec_ir[6] = 16'h7E00; dec_exp[6] = I_NOP;
        for (int i = 0; i < 7; i++) begin
            load_ir(dec_ir[i]);
            expect_val($sformatf("decode_%02h", dec_ir[i][15:8]), 32'(dec_exp[i]));
            observe(32'(decoded_instruction));
        end

        // Reset mid-run with PC=7, R1=5, nonzero flags
        write_reg(2'd1, 16'd5);
        load_ir(16'h0107);
        branch = 1'b1; pc_enable = 1'b1;
        step();
        branch = 1'b0; pc_enable = 1'b0;
        load_ir(16'h8220);
        expect_val("pre_rst_pc", 32'd7);          observe(32'(ram_addr));
        expect_val("pre_rst_r1", 32'd5);          observe(32'(data_out));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        expect_val("arst_pc",    32'd0);          observe(32'(ram_addr));
        expect_val("arst_dout",  32'd0);          observe(32'(data_out));
        expect_val("arst_dec",   32'(I_NOP));     observe(32'(decoded_instruction));
        expect_val("arst_flags", 32'd0);          observe(flags());
        step();
        rst_n = 1'b1;
        step();
        load_ir(16'h8220);
        expect_val("post_rst_r1", 32'd0);         observe(32'(data_out));

        if (sb_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL sb_leftover: observed %0d entries expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
